divider_seq_n: RTL and testbench

Sequential unsigned restoring divider that sequences one shared `subtractor_n` instance over `nb_bit` iterations, producing one quotient bit per clock. It sits beside the combinational arithmetic blocks and provides division without replicating `nb_bit` subtractors. A start/done handshake drives it, and results stay stable until the next accepted start.

---
 rtl/divider_pkg.sv | 13 +
 rtl/subtractor_n.sv | 24 ++
 rtl/divider_seq_n.sv | 135 +++++++++++++
 tb/tb_divider_seq_n.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider.
// Contents: FSM state type and the default operand width.
package divider_pkg;

  localparam int unsigned DIVIDER_DEFAULT_NB_BIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtractor_n.sv
// Unsigned nb_bit-wide subtractor: diff_o = a_i - b_i.
// Ports:
//   a_i, b_i  minuend / subtrahend
//   diff_o    difference (mod 2^nb_bit)
//   borrow_o  carry-out of a_i + ~b_i + 1; high when a_i >= b_i
module subtractor_n #(
  parameter int unsigned nb_bit = 8
) (
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic [nb_bit-1:0] diff_o,
  output logic              borrow_o
);

  localparam int unsigned SW = nb_bit + 1;

  logic [SW-1:0] sum;

  // Two's-complement subtraction; the carry-out doubles as the "no borrow" flag.
  assign sum      = {1'b0, a_i} + {1'b0, ~b_i} + SW'(1);
  assign diff_o   = sum[nb_bit-1:0];
  assign borrow_o = sum[nb_bit];

endmodule

// File: rtl/divider_seq_n.sv
// Sequential unsigned restoring divider, one quotient bit per clock, using a
// single shared subtractor_n over nb_bit iterations.
// Optional feature: define DIVIDER_SEQ_ZERO_CHECK_EN to short-circuit a zero
// divisor straight to DONE and flag div_by_zero_o.
// Ports:
//   clk_i, rst_i   clock (rising edge), async active-high reset
//   start_i        request, accepted only in IDLE
//   dividend_i     dividend, sampled on accept
//   divisor_i      divisor, sampled on accept
//   busy_o         high whenever not IDLE
//   done_o         one-cycle result pulse
//   quotient_o     quotient
//   remainder_o    remainder
//   div_by_zero_o  divisor was zero (tied 0 without the zero-check feature)
module divider_seq_n
  import divider_pkg::*;
#(
  parameter int unsigned nb_bit = DIVIDER_DEFAULT_NB_BIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [nb_bit-1:0] dividend_i,
  input  logic [nb_bit-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [nb_bit-1:0] quotient_o,
  output logic [nb_bit-1:0] remainder_o,
  output logic              div_by_zero_o
);

  localparam int unsigned RW    = nb_bit + 1;
  localparam int unsigned CNT_W = $clog2(nb_bit);

  state_t            state, state_nxt;
  logic [RW-1:0]     rem_q;
  logic [nb_bit-1:0] quo_q;
  logic [nb_bit-1:0] div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;

  logic [RW-1:0]     t_val;
  logic [RW-1:0]     diff;
  logic              ge;
  logic              zero_c;

  // Shift the next dividend bit into the partial remainder.
  assign t_val = {rem_q[nb_bit-1:0], quo_q[nb_bit-1]};

  subtractor_n #(.nb_bit(RW)) u_sub (
    .a_i      (t_val),
    .b_i      ({1'b0, div_q}),
    .diff_o   (diff),
    .borrow_o (ge)
  );

`ifdef DIVIDER_SEQ_ZERO_CHECK_EN
  logic dz_q;
  assign zero_c        = (divisor_i == '0);
  assign div_by_zero_o = dz_q;
`else
  assign zero_c        = 1'b0;
  assign div_by_zero_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i) state_nxt = zero_c ? DONE : RUN;
      RUN:  if (cnt_q == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef DIVIDER_SEQ_ZERO_CHECK_EN
      dz_q   <= 1'b0;
`endif
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start_i) begin
            div_q <= divisor_i;
            cnt_q <= CNT_W'(nb_bit - 1);
`ifdef DIVIDER_SEQ_ZERO_CHECK_EN
            dz_q  <= zero_c;
            if (zero_c) begin
              quo_q <= '1;
              rem_q <= RW'(dividend_i);
            end else begin
              quo_q <= dividend_i;
              rem_q <= '0;
            end
`else
            quo_q <= dividend_i;
            rem_q <= '0;
`endif
          end
        end
        RUN: begin
          // Restore (keep T) when the trial subtraction would go negative.
          quo_q <= {quo_q[nb_bit-2:0], ge};
          rem_q <= ge ? diff : t_val;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[nb_bit-1:0];

endmodule

// File: tb/tb_divider_seq_n.sv
// Self-checking bench for divider_seq_n (nb_bit = 8), scoreboard based.
// Honors DIVIDER_SEQ_ZERO_CHECK_EN for zero-divisor expectations.
module tb_divider_seq_n;

  localparam int unsigned NB = 8;

`ifdef DIVIDER_SEQ_ZERO_CHECK_EN
  localparam int  ZLAT = 0;
  localparam logic ZDZ = 1'b1;
`else
  localparam int  ZLAT = NB;
  localparam logic ZDZ = 1'b0;
`endif

  typedef struct {
    logic [NB-1:0] q;
    logic [NB-1:0] r;
    logic          dz;
    int            c0;
    int            lat;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [NB-1:0] dividend_i = '0;
  logic [NB-1:0] divisor_i = '0;
  logic          busy_o, done_o, div_by_zero_o;
  logic [NB-1:0] quotient_o, remainder_o;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic last_dz = 1'b0;

  divider_seq_n #(.nb_bit(NB)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic exp_t make_exp(input logic [NB-1:0] a, input logic [NB-1:0] b, input int c0);
    exp_t e;
    e.c0 = c0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = ZDZ; e.lat = ZLAT;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = NB;
    end
    return e;
  endfunction

  // Monitor: busy/done timing every cycle, result at the expected done cycle.
  logic mon_busy_exp, mon_done_exp;
  exp_t mon_e;
  always @(posedge clk_i) begin
    #2;
    if (!rst_i) begin
      if (sb.size() > 0 && cyc >= sb[0].c0) begin
        mon_busy_exp = 1'b1;
        mon_done_exp = (cyc == sb[0].c0 + sb[0].lat);
      end else begin
        mon_busy_exp = 1'b0;
        mon_done_exp = 1'b0;
      end
      n_checks++;
      if (busy_o !== mon_busy_exp) begin
        n_fail++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, mon_busy_exp);
      end
      n_checks++;
      if (done_o !== mon_done_exp) begin
        n_fail++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done_o, mon_done_exp);
      end
      if (mon_done_exp) begin
        mon_e = sb.pop_front();
        n_checks++;
        if (quotient_o !== mon_e.q) begin
          n_fail++;
          $display("FAIL quotient cyc=%0d got=%0d exp=%0d", cyc, quotient_o, mon_e.q);
        end
        n_checks++;
        if (remainder_o !== mon_e.r) begin
          n_fail++;
          $display("FAIL remainder cyc=%0d got=%0d exp=%0d", cyc, remainder_o, mon_e.r);
        end
        n_checks++;
        if (div_by_zero_o !== mon_e.dz) begin
          n_fail++;
          $display("FAIL div_by_zero cyc=%0d got=%b exp=%b", cyc, div_by_zero_o, mon_e.dz);
        end
      end
    end
  end

  // Wait for IDLE (bounded), then issue one accepted operation.
  task automatic issue(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int w;
    w = 0;
    @(negedge clk_i);
    while (busy_o !== 1'b0 && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    n_checks++;
    if (w >= 100) begin
      n_fail++;
      $display("FAIL issue_timeout cyc=%0d busy=%b exp=0", cyc, busy_o);
    end
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    sb.push_back(make_exp(a, b, cyc + 1));
    last_dz    = (b == '0) ? ZDZ : 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 200) begin
      @(negedge clk_i);
      w++;
    end
    n_checks++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({busy_o, done_o, quotient_o, remainder_o, div_by_zero_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0",
               {busy_o, done_o, quotient_o, remainder_o, div_by_zero_o});
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({busy_o, done_o, quotient_o, remainder_o} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle got=%h exp=0", {busy_o, done_o, quotient_o, remainder_o});
    end
  endtask

  task automatic test_directed();
    issue(8'd200, 8'd7);
    issue(8'd255, 8'd1);
    issue(8'd5, 8'd9);
    issue(8'd0, 8'd3);
    issue(8'd255, 8'd255);
    issue(8'd254, 8'd255);
    drain();
  endtask

  task automatic test_zero_div();
    issue(8'd77, 8'd0);
    drain();
    n_checks++;
    if (div_by_zero_o !== last_dz) begin
      n_fail++;
      $display("FAIL dz_hold got=%b exp=%b", div_by_zero_o, last_dz);
    end
    issue(8'd9, 8'd2);
    drain();
    n_checks++;
    if (div_by_zero_o !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_clear got=%b exp=0", div_by_zero_o);
    end
  endtask

  task automatic test_start_ignored();
    exp_t e1, e2;
    int w;
    @(negedge clk_i);
    start_i    = 1'b1;
    dividend_i = 8'd200;
    divisor_i  = 8'd7;
    e1 = make_exp(8'd200, 8'd7, cyc + 1);
    e2 = make_exp(8'd10, 8'd3, e1.c0 + NB + 2);
    sb.push_back(e1);
    sb.push_back(e2);
    @(negedge clk_i);
    dividend_i = 8'd10;
    divisor_i  = 8'd3;
    w = 0;
    while (cyc < e2.c0 && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    start_i = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    issue(8'd123, 8'd4);
    repeat (3) @(posedge clk_i);
    #4;
    rst_i = 1'b1;
    sb.delete();
    #1;
    n_checks++;
    if ({busy_o, done_o, quotient_o, remainder_o, div_by_zero_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=0",
               {busy_o, done_o, quotient_o, remainder_o, div_by_zero_o});
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (12) @(negedge clk_i);
    issue(8'd100, 8'd10);
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      issue(NB'($urandom_range(0, 255)), NB'($urandom_range(0, 255)));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_div();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
